// File: rtl/dotprod_seq_ctrl.sv
// Sequencer and accumulator for a LEN-wide dot-product datapath computing C = A x B.
// Optional: define DOTPROD_SEQ_SATURATE_EN for signed saturating accumulation.
module dotprod_seq_ctrl #(
  parameter int N     = 32,
  parameter int LEN   = 4,
  parameter int DIM_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_n,
  input  logic [DIM_W-1:0] cfg_kc,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             rd_en,
  output logic [DIM_W-1:0] rd_row,
  output logic [DIM_W-1:0] rd_col,
  output logic [DIM_W-1:0] rd_chunk,
  input  logic [N-1:0]     dp_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic [DIM_W-1:0] res_row,
  output logic [DIM_W-1:0] res_col
);

  if (LEN < 1) begin : g_bad_len
    $error("LEN must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT, S_DONE, S_ERR} state_t;

  localparam logic [DIM_W-1:0] ONE = {{(DIM_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DIM_W-1:0] m_q, m_d, n_q, n_d, kc_q, kc_d;
  logic [DIM_W-1:0] r_q, r_d, c_q, c_d, k_q, k_d;
  logic             err_q, err_d;
  logic             vld_p1_q, first_p1_q;
  logic signed [N-1:0] acc_q, acc_d;

`ifdef DOTPROD_SEQ_SATURATE_EN
  localparam logic signed [N-1:0] ACC_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] ACC_MIN = {1'b1, {(N-1){1'b0}}};

  logic clamp_q, clamp_d;

  // Returns {overflow, clamped sum}.
  function automatic logic [N:0] sat_add(input logic signed [N-1:0] a,
                                         input logic signed [N-1:0] b);
    logic signed [N-1:0] s;
    logic                ovf;
    s   = a + b;
    ovf = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    if (ovf) s = a[N-1] ? ACC_MIN : ACC_MAX;
    return {ovf, s};
  endfunction

  always_comb begin
    acc_d   = acc_q;
    clamp_d = clamp_q;
    if (vld_p1_q) begin
      if (first_p1_q) begin
        acc_d   = $signed(dp_result);
        clamp_d = 1'b0;
      end else if (!clamp_q) begin
        {clamp_d, acc_d} = sat_add(acc_q, $signed(dp_result));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clamp_q <= 1'b0;
    else          clamp_q <= clamp_d;
  end
`else
  function automatic logic signed [N-1:0] wrap_add(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
    return a + b;
  endfunction

  always_comb begin
    acc_d = acc_q;
    if (vld_p1_q) acc_d = first_p1_q ? $signed(dp_result) : wrap_add(acc_q, $signed(dp_result));
  end
`endif

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_d       = n_q;
    kc_d      = kc_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    err_d     = err_q;
    rd_en     = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d   = cfg_m;
          n_d   = cfg_n;
          kc_d  = cfg_kc;
          err_d = 1'b0;
          if (cfg_m == '0 || cfg_n == '0 || cfg_kc == '0) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            r_d     = '0;
            c_d     = '0;
            k_d     = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        rd_en = 1'b1;
        if (k_q == kc_q - ONE) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + ONE;
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (c_q < n_q - ONE) begin
            c_d     = c_q + ONE;
            state_d = S_ISSUE;
          end else if (r_q < m_q - ONE) begin
            c_d     = '0;
            r_d     = r_q + ONE;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      kc_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      err_q      <= 1'b0;
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      kc_q       <= kc_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      err_q      <= err_d;
      // p1: read issued last cycle, its dp_result is on the bus now
      vld_p1_q   <= rd_en;
      first_p1_q <= rd_en && (k_q == '0);
      acc_q      <= acc_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign err_cfg  = err_q;
  assign rd_row   = r_q;
  assign rd_col   = c_q;
  assign rd_chunk = k_q;
  assign res_data = acc_q;
  assign res_row  = r_q;
  assign res_col  = c_q;

endmodule

// File: tb/tb_dotprod_seq_ctrl.sv
// Randomized bench for dotprod_seq_ctrl with a matrix-level reference model.
module tb_dotprod_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_m = '0, cfg_n = '0, cfg_kc = '0;
  logic        busy, done, err_cfg, rd_en, res_valid;
  logic [4:0]  rd_row, rd_col, rd_chunk, res_row, res_col;
  logic [31:0] dp_result = '0;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;

  dotprod_seq_ctrl #(.N(32), .LEN(4), .DIM_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_kc(cfg_kc),
    .busy(busy), .done(done), .err_cfg(err_cfg),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_chunk(rd_chunk),
    .dp_result(dp_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_col(res_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] tbl [0:31][0:31][0:31];
  logic [14:0] exp_rd[$];
  logic [41:0] exp_res[$];
  logic        prev_v = 1'b0;
  logic [4:0]  prev_r = '0, prev_c = '0, prev_k = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // One element of C: sum over chunks of the per-chunk dot products.
  function automatic logic [31:0] model_elem(int r, int c, int kc);
`ifdef DOTPROD_SEQ_SATURATE_EN
    longint s = 0;
    bit     clamped = 0;
    for (int k = 0; k < kc; k++) begin
      longint v;
      v = longint'($signed(tbl[r][c][k]));
      if (k == 0) begin
        s = v;
        clamped = 0;
      end else if (!clamped) begin
        s = s + v;
        if (s > 64'sd2147483647) begin s = 64'sd2147483647; clamped = 1; end
        else if (s < -64'sd2147483648) begin s = -64'sd2147483648; clamped = 1; end
      end
    end
    return s[31:0];
`else
    logic [31:0] s = '0;
    for (int k = 0; k < kc; k++) s = s + tbl[r][c][k];
    return s;
`endif
  endfunction

  task automatic fill_rand(input int m, input int n, input int kc);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++)
        for (int k = 0; k < kc; k++)
          tbl[r][c][k] = $urandom();
  endtask

  // mode: 0 ready always high, 1 random ready, 2 ready low for the first 5 valid cycles
  task automatic run_job(input int m, input int n, input int kc, input int mode,
                         input int abort_at, input bit mid_start);
    bit          zero;
    bit          done_now, done_next, expect_rd_next, hold_prev;
    logic [42:0] held;
    int          hold_cnt, first_valid_cyc, last_hs;
    zero = (m == 0 || n == 0 || kc == 0);
    exp_rd.delete();
    exp_res.delete();
    if (!zero)
      for (int r = 0; r < m; r++)
        for (int c = 0; c < n; c++) begin
          for (int k = 0; k < kc; k++) exp_rd.push_back({5'(r), 5'(c), 5'(k)});
          exp_res.push_back({model_elem(r, c, kc), 5'(r), 5'(c)});
        end
    done_now = zero; done_next = 0; expect_rd_next = 0; hold_prev = 0; held = '0;
    hold_cnt = 0; first_valid_cyc = -1; last_hs = -1;

    @(negedge clk);
    cfg_m = 5'(m); cfg_n = 5'(n); cfg_kc = 5'(kc);
    start = 1'b1;
    res_ready = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start  = (mid_start && cyc == 2);
      cfg_m  = 5'($urandom()); cfg_n = 5'($urandom()); cfg_kc = 5'($urandom());
      dp_result = prev_v ? tbl[prev_r][prev_c][prev_k] : $urandom();
      prev_v = rd_en; prev_r = rd_row; prev_c = rd_col; prev_k = rd_chunk;

      if (abort_at == cyc) begin
        reset_n = 1'b0;
        #1;
        check_eq("abort_outputs",
                 {busy, done, err_cfg, rd_en, rd_row, rd_col, rd_chunk,
                  res_valid, res_data, res_row, res_col}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        prev_v  = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        check_eq("abort_no_done", done, 1'b0);
        check_eq("abort_idle", busy, 1'b0);
        return;
      end

      if (cyc == 1) begin
        check_eq("first_rd", rd_en, !zero);
        check_eq("err_cfg", err_cfg, zero);
        check_eq("busy", busy, 1'b1);
      end
      if (expect_rd_next) check_eq("rd_after_hs", rd_en, 1'b1);
      expect_rd_next = 0;
      if (rd_en) begin
        if (exp_rd.size() == 0) check_eq("rd_extra", 1'b1, 1'b0);
        else check_eq("rd_idx", {rd_row, rd_col, rd_chunk}, exp_rd.pop_front());
      end

      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = !res_valid || hold_cnt >= 5;
      endcase
      if (res_valid) hold_cnt++;

      if (hold_prev) check_eq("hold", {res_valid, res_data, res_row, res_col}, held);
      if (res_valid && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        if (mode == 0) check_eq("first_valid_cyc", cyc, kc + 2);
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) check_eq("res_extra", 1'b1, 1'b0);
        else check_eq("res", {res_data, res_row, res_col}, exp_res.pop_front());
        if (mode == 0 && last_hs > 0) check_eq("thruput", cyc - last_hs, kc + 2);
        last_hs = cyc;
        if (exp_res.size() == 0) done_next = 1;
        else expect_rd_next = 1;
      end
      hold_prev = res_valid && !res_ready;
      held = {res_valid, res_data, res_row, res_col};

      check_eq("done", done, done_now);
      if (done) begin
        @(negedge clk);
        check_eq("done_1cyc", done, 1'b0);
        check_eq("idle", busy, 1'b0);
        check_eq("rd_left", exp_rd.size(), 0);
        check_eq("res_left", exp_res.size(), 0);
        return;
      end
      done_now = done_next;
      done_next = 0;
    end
    check_eq("timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check_eq("reset_outputs",
             {busy, done, err_cfg, rd_en, rd_row, rd_col, rd_chunk,
              res_valid, res_data, res_row, res_col}, '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) tbl[r][c][0] = 32'(r * 10 + c);
    run_job(2, 2, 1, 0, -1, 0);

    tbl[0][0][0] = 32'd5; tbl[0][0][1] = 32'd7; tbl[0][0][2] = 32'd9;
    run_job(1, 1, 3, 0, -1, 0);

    fill_rand(1, 2, 2);
    run_job(1, 2, 2, 2, -1, 0);

    run_job(1, 0, 3, 0, -1, 0);
    check_eq("err_sticky", err_cfg, 1'b1);
    run_job(0, 2, 2, 0, -1, 0);
    run_job(2, 2, 0, 0, -1, 0);
    fill_rand(2, 3, 2);
    run_job(2, 3, 2, 1, -1, 0);
    check_eq("err_cleared", err_cfg, 1'b0);

    fill_rand(3, 3, 4);
    run_job(3, 3, 4, 0, 3, 1);
    fill_rand(2, 2, 3);
    run_job(2, 2, 3, 0, -1, 0);

    tbl[0][0][0] = 32'h7FFF_FFFF; tbl[0][0][1] = 32'h7FFF_FFFF;
    run_job(1, 1, 2, 0, -1, 0);

    fill_rand(31, 2, 1);
    run_job(31, 2, 1, 1, -1, 0);
    fill_rand(1, 1, 31);
    run_job(1, 1, 31, 0, -1, 0);

    for (int j = 0; j < 8; j++) begin
      int m, n, kc, mode;
      m = $urandom_range(1, 3); n = $urandom_range(1, 3);
      kc = $urandom_range(1, 5); mode = $urandom_range(0, 2);
      fill_rand(m, n, kc);
      run_job(m, n, kc, mode, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
